// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: owns the PC, fetches over a req/ack handshake,
// presents the latched instruction to decode and redirects on JUMP/JAL.
module instr_fetch_unit #(
  parameter int ADDR_W   = 12,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       instr,
  output logic [3:0]        opcode,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] link_addr,
  output logic              link_we,
  output logic [CNT_W-1:0]  retired_cnt
);

  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]        OP_JUMP    = 4'b1010;
  localparam logic [3:0]        OP_JAL     = 4'b0111;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              is_jump;
  logic              is_jal;

  // The fetch address is the PC flop itself, so imem_addr has no input-to-output path.
  assign imem_addr = pc;
  assign opcode    = instr[15:12];
  assign is_jump   = (instr[15:12] == OP_JUMP);
  assign is_jal    = (instr[15:12] == OP_JAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_ADDR;
      imem_req    <= 1'b0;
      instr       <= 16'h0000;
      instr_valid <= 1'b0;
      pc_out      <= '0;
      link_addr   <= '0;
      link_we     <= 1'b0;
      retired_cnt <= '0;
    end else begin
      link_we <= 1'b0;
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            pc_out      <= pc;
            pc          <= pc + ADDR_ONE;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          // pc already holds pc_out+1; only a redirect overrides it on the consume edge.
          if (!stall) begin
            if (retired_cnt != '1) retired_cnt <= retired_cnt + CNT_ONE;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= REQ;
            if (is_jump || is_jal) pc <= instr[ADDR_W-1:0];
            if (is_jal) begin
              link_addr <= pc_out + ADDR_ONE;
              link_we   <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit: a 12-bit default instance
// and a 4-bit/2-bit-counter instance for wrap, RESET_PC and saturation.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Instance A: default parameters.
  logic        rst_a = 1'b1, stall_a = 1'b0, ack_a = 1'b0;
  logic [15:0] rdata_a = 16'h0000;
  logic        req_a, valid_a, link_we_a;
  logic [11:0] addr_a, pc_out_a, link_addr_a;
  logic [15:0] instr_a, cnt_a;
  logic [3:0]  opcode_a;

  instr_fetch_unit dut_a (
    .clk(clk), .rst(rst_a), .stall(stall_a),
    .imem_req(req_a), .imem_addr(addr_a), .imem_ack(ack_a), .imem_rdata(rdata_a),
    .instr(instr_a), .opcode(opcode_a), .instr_valid(valid_a), .pc_out(pc_out_a),
    .link_addr(link_addr_a), .link_we(link_we_a), .retired_cnt(cnt_a)
  );

  // Instance B: narrow address, non-zero reset PC, tiny counter.
  logic        rst_b = 1'b1, stall_b = 1'b0, ack_b = 1'b0;
  logic [15:0] rdata_b = 16'h0000;
  logic        req_b, valid_b, link_we_b;
  logic [3:0]  addr_b, pc_out_b, link_addr_b, opcode_b;
  logic [15:0] instr_b;
  logic [1:0]  cnt_b;

  instr_fetch_unit #(.ADDR_W(4), .RESET_PC(14), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst_b), .stall(stall_b),
    .imem_req(req_b), .imem_addr(addr_b), .imem_ack(ack_b), .imem_rdata(rdata_b),
    .instr(instr_b), .opcode(opcode_b), .instr_valid(valid_b), .pc_out(pc_out_b),
    .link_addr(link_addr_b), .link_we(link_we_b), .retired_cnt(cnt_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic a, input logic [15:0] d);
    rst_a = r; stall_a = s; ack_a = a; rdata_a = d;
    @(posedge clk); #1;
  endtask

  task automatic applyStimulusB(input logic r, input logic a, input logic [15:0] d);
    rst_b = r; ack_b = a; rdata_b = d;
    @(posedge clk); #1;
  endtask

  logic [15:0] seq_words [3] = '{16'h1123, 16'h2456, 16'h4789};
  logic [3:0]  seq_ops   [3] = '{4'h1, 4'h2, 4'h4};

  initial begin
    // Reset state
    applyStimulus(1, 0, 0, 16'h0);
    applyStimulus(1, 0, 0, 16'h0);
    checkOutput("rst_req", 32'(req_a), 0);
    checkOutput("rst_addr", 32'(addr_a), 0);
    checkOutput("rst_instr", 32'(instr_a), 0);
    checkOutput("rst_valid", 32'(valid_a), 0);
    checkOutput("rst_pc_out", 32'(pc_out_a), 0);
    checkOutput("rst_link", 32'(link_addr_a), 0);
    checkOutput("rst_link_we", 32'(link_we_a), 0);
    checkOutput("rst_cnt", 32'(cnt_a), 0);

    // IDLE for one cycle, then REQ at address 0
    applyStimulus(0, 0, 0, 16'h0);
    checkOutput("first_req", 32'(req_a), 1);
    checkOutput("first_addr", 32'(addr_a), 0);

    // Sequential fetch with immediate acks
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, seq_words[i]);
      checkOutput("seq_valid", 32'(valid_a), 1);
      checkOutput("seq_instr", 32'(instr_a), 32'(seq_words[i]));
      checkOutput("seq_opcode", 32'(opcode_a), 32'(seq_ops[i]));
      checkOutput("seq_pc_out", 32'(pc_out_a), 32'(i));
      checkOutput("seq_req_drop", 32'(req_a), 0);
      applyStimulus(0, 0, 0, 16'h0);
      checkOutput("seq_consumed", 32'(valid_a), 0);
      checkOutput("seq_next_req", 32'(req_a), 1);
      checkOutput("seq_next_addr", 32'(addr_a), 32'(i + 1));
      checkOutput("seq_cnt", 32'(cnt_a), 32'(i + 1));
    end

    // Delayed ack: request and address hold steady
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 16'h0);
      checkOutput("wait_req", 32'(req_a), 1);
      checkOutput("wait_addr", 32'(addr_a), 3);
      checkOutput("wait_valid", 32'(valid_a), 0);
    end
    applyStimulus(0, 1, 1, 16'h3ABC);
    checkOutput("late_valid", 32'(valid_a), 1);
    checkOutput("late_instr", 32'(instr_a), 32'h3ABC);
    checkOutput("late_pc_out", 32'(pc_out_a), 3);

    // Stalled HOLD, including a stray ack that must be ignored
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, (k == 1), 16'hFFFF);
      checkOutput("stall_valid", 32'(valid_a), 1);
      checkOutput("stall_instr", 32'(instr_a), 32'h3ABC);
      checkOutput("stall_pc_out", 32'(pc_out_a), 3);
      checkOutput("stall_req", 32'(req_a), 0);
      checkOutput("stall_cnt", 32'(cnt_a), 3);
    end
    applyStimulus(0, 0, 0, 16'h0);
    checkOutput("unstall_cnt", 32'(cnt_a), 4);
    checkOutput("unstall_req", 32'(req_a), 1);
    checkOutput("unstall_addr", 32'(addr_a), 4);

    // JUMP 0x003 from pc 4, then JUMP 0x0F5 from pc 3
    applyStimulus(0, 0, 1, 16'hA003);
    checkOutput("j1_pc_out", 32'(pc_out_a), 4);
    applyStimulus(0, 0, 0, 16'h0);
    checkOutput("j1_target", 32'(addr_a), 3);
    applyStimulus(0, 0, 1, 16'hA0F5);
    checkOutput("j2_pc_out", 32'(pc_out_a), 3);
    checkOutput("j2_opcode", 32'(opcode_a), 32'hA);
    applyStimulus(0, 0, 0, 16'h0);
    checkOutput("j2_target", 32'(addr_a), 32'h0F5);
    checkOutput("j2_req", 32'(req_a), 1);
    checkOutput("j2_link_we", 32'(link_we_a), 0);
    checkOutput("j2_cnt", 32'(cnt_a), 6);

    // JAL 0x200 from pc 0x010
    applyStimulus(0, 0, 1, 16'hA010);
    applyStimulus(0, 0, 0, 16'h0);
    checkOutput("jal_pre_addr", 32'(addr_a), 32'h010);
    applyStimulus(0, 0, 1, 16'h7200);
    checkOutput("jal_pc_out", 32'(pc_out_a), 32'h010);
    applyStimulus(0, 0, 0, 16'h0);
    checkOutput("jal_target", 32'(addr_a), 32'h200);
    checkOutput("jal_link_we", 32'(link_we_a), 1);
    checkOutput("jal_link_addr", 32'(link_addr_a), 32'h011);
    checkOutput("jal_cnt", 32'(cnt_a), 8);
    applyStimulus(0, 0, 0, 16'h0);
    checkOutput("jal_we_pulse", 32'(link_we_a), 0);
    checkOutput("jal_link_hold", 32'(link_addr_a), 32'h011);
    checkOutput("jal_req_hold", 32'(req_a), 1);

    // Reset during REQ with a simultaneous ack
    applyStimulus(1, 0, 1, 16'h5555);
    checkOutput("rreq_req", 32'(req_a), 0);
    checkOutput("rreq_instr", 32'(instr_a), 0);
    checkOutput("rreq_valid", 32'(valid_a), 0);
    checkOutput("rreq_addr", 32'(addr_a), 0);
    checkOutput("rreq_cnt", 32'(cnt_a), 0);
    checkOutput("rreq_link", 32'(link_addr_a), 0);
    applyStimulus(0, 0, 0, 16'h0);
    checkOutput("rreq_restart_req", 32'(req_a), 1);
    checkOutput("rreq_restart_addr", 32'(addr_a), 0);

    // Reset during HOLD of a JAL: no retire, no link write
    applyStimulus(0, 0, 1, 16'h7123);
    checkOutput("rhold_valid", 32'(valid_a), 1);
    applyStimulus(1, 0, 0, 16'h0);
    checkOutput("rhold_valid_clr", 32'(valid_a), 0);
    checkOutput("rhold_cnt", 32'(cnt_a), 0);
    checkOutput("rhold_link_we", 32'(link_we_a), 0);
    checkOutput("rhold_instr", 32'(instr_a), 0);
    applyStimulus(0, 0, 0, 16'h0);
    checkOutput("rhold_link_we2", 32'(link_we_a), 0);

    // Instance B: RESET_PC=14, 4-bit wrap, counter saturation
    applyStimulusB(1, 0, 16'h0);
    checkOutput("b_rst_addr", 32'(addr_b), 32'hE);
    checkOutput("b_rst_req", 32'(req_b), 0);
    applyStimulusB(0, 0, 16'h0);
    checkOutput("b_req_addr", 32'(addr_b), 32'hE);
    applyStimulusB(0, 1, 16'h1000);
    checkOutput("b_pc_out_e", 32'(pc_out_b), 32'hE);
    applyStimulusB(0, 0, 16'h0);
    checkOutput("b_addr_f", 32'(addr_b), 32'hF);
    applyStimulusB(0, 1, 16'h2000);
    checkOutput("b_pc_out_f", 32'(pc_out_b), 32'hF);
    checkOutput("b_wrap_pc", 32'(addr_b), 0);
    applyStimulusB(0, 0, 16'h0);
    checkOutput("b_wrap_addr", 32'(addr_b), 0);
    checkOutput("b_cnt2", 32'(cnt_b), 2);
    applyStimulusB(0, 1, 16'hA00F);
    applyStimulusB(0, 0, 16'h0);
    checkOutput("b_jump_f", 32'(addr_b), 32'hF);
    checkOutput("b_cnt3", 32'(cnt_b), 3);
    applyStimulusB(0, 1, 16'h7005);
    checkOutput("b_jal_pc_out", 32'(pc_out_b), 32'hF);
    applyStimulusB(0, 0, 16'h0);
    checkOutput("b_jal_target", 32'(addr_b), 5);
    checkOutput("b_jal_we", 32'(link_we_b), 1);
    checkOutput("b_link_wrap", 32'(link_addr_b), 0);
    checkOutput("b_cnt_sat", 32'(cnt_b), 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
